// File: rtl/dcache_ctrl_pkg.sv
// Shared types and constants for the D-Cache request sequencer.
// FULL_STRB is wide enough for any byte-enable width up to 64 lanes.
package dcache_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam logic [63:0] FULL_STRB  = '1;
  localparam int          MISS_CNT_W = 32;

endpackage

// File: rtl/dcache_byte_merge.sv
// Combinational byte-lane merge: lanes with wstrb set come from new_word,
// the rest keep old_word.
module dcache_byte_merge #(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0]   old_word,
  input  logic [DATA_W-1:0]   new_word,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   merged
);

  always_comb begin
    merged = old_word;
    for (int i = 0; i < DATA_W/8; i++) begin
      if (wstrb[i]) merged[i*8 +: 8] = new_word[i*8 +: 8];
    end
  end

endmodule

// File: rtl/dcache_req_ctrl.sv
// MEM-stage to D-Cache request sequencer: loads, full stores, read-modify-write
// partial stores, per-phase timeout, pipeline hold and saturating miss count.
//
//   state | meaning
//   IDLE  | waiting for a request; accepts when req_valid_i and no interrupt
//   RD    | cache read (load, or first half of a partial store)
//   WR    | cache write (full store, or merged word of a partial store)
//   RESP  | done_o pulse, err_o if a phase timed out
module dcache_req_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 64,
  parameter int TMO_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  input  logic                  req_rw_i,
  input  logic [ADDR_W-1:0]     req_addr_i,
  input  logic [DATA_W-1:0]     req_wdata_i,
  input  logic [DATA_W/8-1:0]   req_wstrb_i,
  input  logic                  int_assert_i,
  output logic                  done_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  err_o,
  output logic                  hold_o,
  output logic [MISS_CNT_W-1:0] miss_cnt_o,
  output logic [ADDR_W-1:0]     dcache_req_addr,
  output logic                  dcache_req_valid,
  output logic                  dcache_req_rw,
  output logic [DATA_W-1:0]     dcache_data_write,
  input  logic [DATA_W-1:0]     dcache_data_read,
  input  logic                  dcache_ready,
  input  logic                  dcache_hit
);

  localparam int STRB_W = DATA_W/8;
  localparam int TMR_W  = $clog2(TMO_CYCLES + 1);
  localparam logic [STRB_W-1:0] STRB_ALL = FULL_STRB[STRB_W-1:0];

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, buf_q, rdata_q, merged;
  logic [STRB_W-1:0]   wstrb_q;
  logic                rw_q, err_q;
  logic [TMR_W-1:0]    tmr_q;
  logic [MISS_CNT_W-1:0] miss_q;
  logic                accept, in_phase, tmo;

  // Gating with rst_n keeps hold_o low while reset is asserted.
  assign accept   = rst_n & (state_q == IDLE) & req_valid_i & ~int_assert_i;
  assign in_phase = (state_q == RD) | (state_q == WR);
  assign tmo      = in_phase & ~dcache_ready & (tmr_q == TMR_W'(1));

  dcache_byte_merge #(.DATA_W(DATA_W)) u_merge (
    .old_word (dcache_data_read),
    .new_word (wdata_q),
    .wstrb    (wstrb_q),
    .merged   (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!req_rw_i)                  state_d = RD;
          else if (req_wstrb_i == STRB_ALL) state_d = WR;
          else if (req_wstrb_i == '0)     state_d = RESP;
          else                            state_d = RD;
        end
      end
      RD: begin
        if (dcache_ready) state_d = rw_q ? WR : RESP;
        else if (tmo)     state_d = RESP;
      end
      WR: begin
        if (dcache_ready || tmo) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rw_q    <= 1'b0;
      buf_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tmr_q   <= '0;
      miss_q  <= '0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        wstrb_q <= req_wstrb_i;
        rw_q    <= req_rw_i;
        err_q   <= 1'b0;
        tmr_q   <= TMR_W'(TMO_CYCLES);
      end
      if (in_phase && dcache_ready) begin
        tmr_q <= TMR_W'(TMO_CYCLES);
        if (state_q == RD) begin
          if (rw_q) buf_q   <= merged;
          else      rdata_q <= dcache_data_read;
        end
        if (!dcache_hit && miss_q != '1) miss_q <= miss_q + 1'b1;
      end else if (tmo) begin
        err_q   <= 1'b1;
        rdata_q <= '0;
      end else if (in_phase) begin
        tmr_q <= tmr_q - 1'b1;
      end
    end
  end

  assign done_o            = (state_q == RESP);
  assign err_o             = done_o & err_q;
  assign hold_o            = accept | in_phase;
  assign rdata_o           = rdata_q;
  assign miss_cnt_o        = miss_q;
  assign dcache_req_valid  = in_phase;
  assign dcache_req_rw     = (state_q == WR);
  assign dcache_req_addr   = in_phase ? addr_q : '0;
  // Full stores write the latched word; partial stores write the merged buffer.
  assign dcache_data_write = (state_q != WR) ? '0 :
                             (wstrb_q == STRB_ALL) ? wdata_q : buf_q;

endmodule

// File: tb/tb_dcache_req_ctrl.sv
// Directed bench for dcache_req_ctrl: a responder plays the D-Cache while a
// scoreboard holds expected completions and writes.
module tb_dcache_req_ctrl;

  logic        clk, rst_n;
  logic        req_valid, req_rw, int_assert;
  logic [11:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        done_o, err_o, hold_o;
  logic [63:0] rdata_o;
  logic [31:0] miss_cnt_o;
  logic [11:0] dcache_req_addr;
  logic        dcache_req_valid, dcache_req_rw;
  logic [63:0] dcache_data_write, dcache_data_read;
  logic        dcache_ready, dcache_hit;

  dcache_req_ctrl #(.ADDR_W(12), .DATA_W(64), .TMO_CYCLES(255)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid_i       (req_valid),
    .req_rw_i          (req_rw),
    .req_addr_i        (req_addr),
    .req_wdata_i       (req_wdata),
    .req_wstrb_i       (req_wstrb),
    .int_assert_i      (int_assert),
    .done_o            (done_o),
    .rdata_o           (rdata_o),
    .err_o             (err_o),
    .hold_o            (hold_o),
    .miss_cnt_o        (miss_cnt_o),
    .dcache_req_addr   (dcache_req_addr),
    .dcache_req_valid  (dcache_req_valid),
    .dcache_req_rw     (dcache_req_rw),
    .dcache_data_write (dcache_data_write),
    .dcache_data_read  (dcache_data_read),
    .dcache_ready      (dcache_ready),
    .dcache_hit        (dcache_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [63:0] rdata; logic err; } resp_t;
  typedef struct { logic [11:0] addr; logic [63:0] data; } wr_t;
  resp_t resp_q[$];
  wr_t   wr_q[$];
  int    rd_seen = 0;
  int    wr_seen = 0;
  logic [63:0] exp_rdata = '0;
  int    exp_miss = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  resp_t mon_r;
  wr_t   mon_w;
  always @(negedge clk) begin
    if (rst_n && done_o) begin
      if (resp_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        mon_r = resp_q.pop_front();
        chk("rdata", rdata_o, mon_r.rdata);
        chk("err", {63'd0, err_o}, {63'd0, mon_r.err});
      end
    end
    if (dcache_req_valid && dcache_ready) begin
      if (dcache_req_rw) begin
        wr_seen++;
        if (wr_q.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          mon_w = wr_q.pop_front();
          chk("wr_addr", {52'd0, dcache_req_addr}, {52'd0, mon_w.addr});
          chk("wr_data", dcache_data_write, mon_w.data);
        end
      end else rd_seen++;
    end
  end

  task automatic run_req(input string tag, input logic rw, input logic [11:0] addr,
                         input logic [63:0] wdata, input logic [7:0] wstrb,
                         input logic [63:0] old_word, input int waits, input logic hit,
                         input int exp_lat, input int exp_rd, input int exp_wr,
                         input logic exp_err, input logic [63:0] exp_wdata, input int int_cyc);
    int n, hc, rd0, wr0, w;
    logic vseen;
    logic [1:0] key, pkey;
    resp_t r;
    wr_t   wr;
    if (exp_err) exp_rdata = '0;
    else if (!rw) exp_rdata = old_word;
    r.rdata = exp_rdata; r.err = exp_err;
    resp_q.push_back(r);
    if (exp_wr != 0) begin wr.addr = addr; wr.data = exp_wdata; wr_q.push_back(wr); end
    if (!hit) exp_miss += exp_rd + exp_wr;
    rd0 = rd_seen; wr0 = wr_seen;
    @(negedge clk);
    req_valid = 1'b1; req_rw = rw; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    dcache_data_read = old_word; dcache_hit = hit; dcache_ready = 1'b0;
    #1 chk({tag, "_hold_accept"}, {63'd0, hold_o}, 64'd1);
    hc = 1; n = 0; w = 0; vseen = 1'b0; pkey = 2'b00;
    while (n < 400) begin
      @(posedge clk); #1; n++;
      if (int_cyc != 0 && n == int_cyc) int_assert = 1'b1;
      if (done_o) break;
      if (hold_o) hc++;
      key = {dcache_req_valid, dcache_req_rw};
      if (key != pkey) w = 0;
      pkey = key;
      if (dcache_req_valid) begin
        vseen = 1'b1;
        dcache_ready = (w >= waits);
        w++;
      end else dcache_ready = 1'b0;
    end
    dcache_ready = 1'b0; req_valid = 1'b0; int_assert = 1'b0;
    chk({tag, "_done_seen"}, {63'd0, done_o}, 64'd1);
    chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
    chk({tag, "_hold_cycles"}, 64'(hc), 64'(exp_lat));
    chk({tag, "_valid_seen"}, {63'd0, vseen}, {63'd0, (exp_rd + exp_wr > 0) || exp_err});
    @(negedge clk); #1;
    chk({tag, "_reads"}, 64'(rd_seen - rd0), 64'(exp_rd));
    chk({tag, "_writes"}, 64'(wr_seen - wr0), 64'(exp_wr));
    chk({tag, "_miss_cnt"}, {32'd0, miss_cnt_o}, 64'(exp_miss));
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, {63'd0, done_o}, 64'd0);
  endtask

  initial begin
    logic vflag;
    rst_n = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_wdata = '0;
    req_wstrb = '0; int_assert = 1'b0; dcache_data_read = '0; dcache_ready = 1'b0;
    dcache_hit = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_done", {63'd0, done_o}, 64'd0);
    chk("rst_hold", {63'd0, hold_o}, 64'd0);
    chk("rst_valid", {63'd0, dcache_req_valid}, 64'd0);
    chk("rst_rdata", rdata_o, 64'd0);
    chk("rst_miss", {32'd0, miss_cnt_o}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_req("load", 1'b0, 12'h010, 64'd0, 8'h00, 64'h1122_3344_5566_7788, 0, 1'b1,
            2, 1, 0, 1'b0, 64'd0, 0);
    run_req("rmw_sb", 1'b1, 12'h020, 64'h0000_0000_00AB_0000, 8'h04, 64'hFFFF_FFFF_FFFF_FFFF,
            0, 1'b0, 3, 1, 1, 1'b0, 64'hFFFF_FFFF_FFAB_FFFF, 0);
    run_req("sd_full", 1'b1, 12'h030, 64'hDEAD_BEEF_0123_4567, 8'hFF, 64'h5555_5555_5555_5555,
            0, 1'b0, 2, 0, 1, 1'b0, 64'hDEAD_BEEF_0123_4567, 0);
    run_req("zero_strb", 1'b1, 12'h040, 64'h1234, 8'h00, 64'h0, 0, 1'b1,
            1, 0, 0, 1'b0, 64'd0, 0);
    run_req("load_wait3", 1'b0, 12'h050, 64'd0, 8'h00, 64'hCAFE_F00D_0000_0001, 3, 1'b0,
            5, 1, 0, 1'b0, 64'd0, 0);
    chk("miss_four", {32'd0, miss_cnt_o}, 64'd4);
    run_req("rmw_tmo", 1'b1, 12'h060, 64'h00FF_00FF_00FF_00FF, 8'h0F, 64'h0, 100000, 1'b0,
            256, 0, 0, 1'b1, 64'd0, 0);

    @(negedge clk);
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 12'h070; int_assert = 1'b1;
    #1 chk("int_block_hold", {63'd0, hold_o}, 64'd0);
    vflag = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (dcache_req_valid || hold_o || done_o) vflag = 1'b1;
    end
    chk("int_block_idle", {63'd0, vflag}, 64'd0);
    @(negedge clk); req_valid = 1'b0; int_assert = 1'b0;

    run_req("sd_int_mid_wr", 1'b1, 12'h080, 64'h0102_0304_0506_0708, 8'hFF, 64'h0, 3, 1'b1,
            5, 0, 1, 1'b0, 64'h0102_0304_0506_0708, 2);

    @(negedge clk);
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 12'h090; dcache_ready = 1'b0; dcache_hit = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("pre_rst_in_rd", {63'd0, dcache_req_valid}, 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_done", {63'd0, done_o}, 64'd0);
    chk("rst_mid_hold", {63'd0, hold_o}, 64'd0);
    chk("rst_mid_err", {63'd0, err_o}, 64'd0);
    chk("rst_mid_valid", {63'd0, dcache_req_valid}, 64'd0);
    chk("rst_mid_rw", {63'd0, dcache_req_rw}, 64'd0);
    chk("rst_mid_addr", {52'd0, dcache_req_addr}, 64'd0);
    chk("rst_mid_wdata", dcache_data_write, 64'd0);
    chk("rst_mid_rdata", rdata_o, 64'd0);
    chk("rst_mid_miss", {32'd0, miss_cnt_o}, 64'd0);
    exp_rdata = '0; exp_miss = 0;
    req_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    vflag = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (dcache_req_valid || hold_o || done_o) vflag = 1'b1;
    end
    chk("rst_release_idle", {63'd0, vflag}, 64'd0);

    run_req("load_after_rst", 1'b0, 12'h0A0, 64'd0, 8'h00, 64'h0BAD_C0DE_8765_4321, 0, 1'b1,
            2, 1, 0, 1'b0, 64'd0, 0);

    repeat (3) @(negedge clk);
    chk("resp_q_empty", 64'(resp_q.size()), 64'd0);
    chk("wr_q_empty", 64'(wr_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
